// File: rtl/dphy_hs_tx.sv
// MIPI D-PHY high-speed transmit sequencer.
// Walks the LP-11 -> LP-01 -> LP-00 -> HS-zero -> sync -> data -> trail -> LP-11
// handshake for one packet at a time. Packet words are sliced into per-lane bytes.
// All outputs are registered.
module dphy_hs_tx #(
  parameter int DATA_LANES   = 2,
  parameter int T_LPX        = 2,
  parameter int T_HS_PREPARE = 2,
  parameter int T_HS_ZERO    = 6,
  parameter int T_HS_TRAIL   = 3,
  parameter int T_HS_EXIT    = 4
) (
  input  logic                    clk_i,
  input  logic                    srst_n_i,
  input  logic [31:0]             data_i,
  input  logic                    valid_i,
  input  logic                    eop_i,
  output logic                    ready_o,
  output logic [DATA_LANES*8-1:0] hs_data_o,
  output logic                    hs_en_o,
  output logic [DATA_LANES-1:0]   lp_p_o,
  output logic [DATA_LANES-1:0]   lp_n_o,
  output logic                    underflow_o
);

  localparam int BEATS = 4 / DATA_LANES;
  localparam int LW    = DATA_LANES * 8;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;

  localparam logic [BW-1:0] LAST_BEAT  = BW'(BEATS - 1);
  localparam logic [7:0]    LPX_LOAD   = 8'(T_LPX - 1);
  localparam logic [7:0]    PREP_LOAD  = 8'(T_HS_PREPARE - 1);
  localparam logic [7:0]    ZERO_LOAD  = 8'(T_HS_ZERO - 1);
  localparam logic [7:0]    TRAIL_LOAD = 8'(T_HS_TRAIL - 1);
  localparam logic [7:0]    EXIT_LOAD  = 8'(T_HS_EXIT - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LP_RQST   = 3'd1,
    LP_BRIDGE = 3'd2,
    HS_ZERO   = 3'd3,
    HS_SYNC   = 3'd4,
    HS_DATA   = 3'd5,
    HS_TRAIL  = 3'd6,
    HS_EXIT   = 3'd7
  } state_t;

  state_t          state_r;
  logic [7:0]      cnt_r;
  logic [BW-1:0]   beat_r;
  logic [31:0]     word_r;
  logic            eop_r;
  logic [BW-1:0]   next_beat_s;

  // Lane bytes for beat k of a word: beat k carries bytes k*DATA_LANES .. k*DATA_LANES+DATA_LANES-1.
  function automatic logic [LW-1:0] beat_bytes(input logic [31:0] w, input logic [BW-1:0] k);
    return LW'(w >> (32'(k) * 32'(LW)));
  endfunction

  // Trail pattern: each lane holds the inverse of the final bit it sent (bit 7 of its last byte).
  function automatic logic [LW-1:0] trail_bytes(input logic [LW-1:0] last);
    logic [LW-1:0] t;
    t = '0;
    for (int i = 0; i < DATA_LANES; i++) begin
      t[i*8 +: 8] = {8{~last[i*8+7]}};
    end
    return t;
  endfunction

  assign next_beat_s = beat_r + BW'(1);

  // Sequencer: state, duration counter, word buffer and all registered outputs.
  always_ff @(posedge clk_i) begin
    if (!srst_n_i) begin
      state_r     <= IDLE;
      cnt_r       <= 8'd0;
      beat_r      <= '0;
      word_r      <= 32'd0;
      eop_r       <= 1'b0;
      ready_o     <= 1'b0;
      hs_en_o     <= 1'b0;
      hs_data_o   <= '0;
      lp_p_o      <= '1;
      lp_n_o      <= '1;
      underflow_o <= 1'b0;
    end else begin
      underflow_o <= 1'b0;
      case (state_r)
        IDLE: begin
          if (valid_i) begin
            state_r <= LP_RQST;
            cnt_r   <= LPX_LOAD;
            lp_p_o  <= '0;
            lp_n_o  <= '1;
          end else begin
            cnt_r   <= 8'd0;
          end
        end
        LP_RQST: begin
          if (cnt_r == 8'd0) begin
            state_r <= LP_BRIDGE;
            cnt_r   <= PREP_LOAD;
            lp_n_o  <= '0;
          end else begin
            cnt_r   <= cnt_r - 8'd1;
          end
        end
        LP_BRIDGE: begin
          if (cnt_r == 8'd0) begin
            state_r   <= HS_ZERO;
            cnt_r     <= ZERO_LOAD;
            hs_en_o   <= 1'b1;
            hs_data_o <= '0;
          end else begin
            cnt_r     <= cnt_r - 8'd1;
          end
        end
        HS_ZERO: begin
          if (cnt_r == 8'd0) begin
            state_r   <= HS_SYNC;
            hs_data_o <= {DATA_LANES{8'hB8}};
            ready_o   <= 1'b1;
          end else begin
            cnt_r     <= cnt_r - 8'd1;
          end
        end
        HS_SYNC, HS_DATA: begin
          if (state_r == HS_DATA && beat_r != LAST_BEAT) begin
            // Mid-word: step to the next beat; offer ready only on the final beat of a non-eop word.
            beat_r    <= next_beat_s;
            hs_data_o <= beat_bytes(word_r, next_beat_s);
            ready_o   <= (next_beat_s == LAST_BEAT) && !eop_r;
          end else if (state_r == HS_DATA && eop_r) begin
            state_r   <= HS_TRAIL;
            cnt_r     <= TRAIL_LOAD;
            ready_o   <= 1'b0;
            hs_data_o <= trail_bytes(hs_data_o);
          end else if (valid_i) begin
            // Word handed over this edge; its beat 0 goes out next cycle with no bubble.
            state_r   <= HS_DATA;
            word_r    <= data_i;
            eop_r     <= eop_i;
            beat_r    <= '0;
            hs_data_o <= data_i[LW-1:0];
            ready_o   <= (LAST_BEAT == BW'(0)) && !eop_i;
          end else begin
            // Starved mid-packet: truncate and close the burst.
            state_r     <= HS_TRAIL;
            cnt_r       <= TRAIL_LOAD;
            ready_o     <= 1'b0;
            underflow_o <= 1'b1;
            hs_data_o   <= trail_bytes(hs_data_o);
          end
        end
        HS_TRAIL: begin
          if (cnt_r == 8'd0) begin
            state_r   <= HS_EXIT;
            cnt_r     <= EXIT_LOAD;
            hs_en_o   <= 1'b0;
            hs_data_o <= '0;
            lp_p_o    <= '1;
            lp_n_o    <= '1;
          end else begin
            cnt_r     <= cnt_r - 8'd1;
          end
        end
        HS_EXIT: begin
          if (cnt_r == 8'd0) begin
            state_r <= IDLE;
          end else begin
            cnt_r   <= cnt_r - 8'd1;
          end
        end
        default: begin
          state_r   <= IDLE;
          cnt_r     <= 8'd0;
          ready_o   <= 1'b0;
          hs_en_o   <= 1'b0;
          hs_data_o <= '0;
          lp_p_o    <= '1;
          lp_n_o    <= '1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dphy_hs_tx.sv
// Testbench for dphy_hs_tx: a 2-lane and a 4-lane instance driven with directed packets.
// Expected output timelines are built from the protocol sequence and checked every cycle.
module tb_dphy_hs_tx;

  localparam int T_LPX        = 2;
  localparam int T_HS_PREPARE = 2;
  localparam int T_HS_ZERO    = 4;
  localparam int T_HS_TRAIL   = 3;
  localparam int T_HS_EXIT    = 2;

  typedef struct packed {
    logic [3:0]  lp_p;
    logic [3:0]  lp_n;
    logic        en;
    logic [31:0] data;
    logic        rdy;
    logic        uf;
  } rec_t;

  logic        clk;
  logic        srst_n;
  logic [31:0] data_in;
  logic        eop_in;
  logic        valid2, valid4;
  logic        rdy2, rdy4, en2, en4, uf2, uf4;
  logic [15:0] hs2;
  logic [31:0] hs4;
  logic [1:0]  lpp2, lpn2;
  logic [3:0]  lpp4, lpn4;

  int   n_pass  = 0;
  int   n_total = 0;
  int   sel     = 0;
  int   pkt_id  = 0;
  int   rec_idx = 0;
  rec_t exp_q[$];
  rec_t tl[$];
  logic [31:0] words [4];

  dphy_hs_tx #(.DATA_LANES(2), .T_LPX(T_LPX), .T_HS_PREPARE(T_HS_PREPARE),
               .T_HS_ZERO(T_HS_ZERO), .T_HS_TRAIL(T_HS_TRAIL), .T_HS_EXIT(T_HS_EXIT))
  u_dut2 (.clk_i(clk), .srst_n_i(srst_n), .data_i(data_in), .valid_i(valid2), .eop_i(eop_in),
          .ready_o(rdy2), .hs_data_o(hs2), .hs_en_o(en2), .lp_p_o(lpp2), .lp_n_o(lpn2),
          .underflow_o(uf2));

  dphy_hs_tx #(.DATA_LANES(4), .T_LPX(T_LPX), .T_HS_PREPARE(T_HS_PREPARE),
               .T_HS_ZERO(T_HS_ZERO), .T_HS_TRAIL(T_HS_TRAIL), .T_HS_EXIT(T_HS_EXIT))
  u_dut4 (.clk_i(clk), .srst_n_i(srst_n), .data_i(data_in), .valid_i(valid4), .eop_i(eop_in),
          .ready_o(rdy4), .hs_data_o(hs4), .hs_en_o(en4), .lp_p_o(lpp4), .lp_n_o(lpn4),
          .underflow_o(uf4));

  // Byte clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // Compare process: one expected record per cycle, sampled on the falling edge.
  always @(negedge clk) begin
    rec_t e, a;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (sel == 1) a = '{lp_p: lpp4, lp_n: lpn4, en: en4, data: hs4, rdy: rdy4, uf: uf4};
      else          a = '{lp_p: {2'b00, lpp2}, lp_n: {2'b00, lpn2}, en: en2,
                          data: {16'h0000, hs2}, rdy: rdy2, uf: uf2};
      n_total++;
      if (a === e) n_pass++;
      else $display("FAIL cycle pkt=%0d idx=%0d actual lp_p=%h lp_n=%h en=%b data=%h rdy=%b uf=%b required lp_p=%h lp_n=%h en=%b data=%h rdy=%b uf=%b",
                    pkt_id, rec_idx, a.lp_p, a.lp_n, a.en, a.data, a.rdy, a.uf,
                    e.lp_p, e.lp_n, e.en, e.data, e.rdy, e.uf);
      rec_idx++;
    end
  end

  task automatic pin(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s actual=%h required=%h", nm, act, req);
  endtask

  function automatic rec_t idle_rec(input int lanes);
    logic [3:0] m;
    m = 4'((1 << lanes) - 1);
    return '{lp_p: m, lp_n: m, en: 1'b0, data: 32'h0, rdy: 1'b0, uf: 1'b0};
  endfunction

  // Expected timeline of one packet, one record per cycle after valid_i is first sampled.
  task automatic build_tl(input int lanes, input int nw, input logic eop_last);
    logic [3:0]  m;
    logic [31:0] dmask, d, last, t, sync;
    int beats;
    m     = 4'((1 << lanes) - 1);
    beats = 4 / lanes;
    dmask = (lanes == 4) ? 32'hFFFF_FFFF : ((32'h1 << (lanes * 8)) - 32'h1);
    tl.delete();
    repeat (T_LPX)        tl.push_back('{lp_p: 4'h0, lp_n: m, en: 1'b0, data: 32'h0, rdy: 1'b0, uf: 1'b0});
    repeat (T_HS_PREPARE) tl.push_back('{lp_p: 4'h0, lp_n: 4'h0, en: 1'b0, data: 32'h0, rdy: 1'b0, uf: 1'b0});
    repeat (T_HS_ZERO)    tl.push_back('{lp_p: 4'h0, lp_n: 4'h0, en: 1'b1, data: 32'h0, rdy: 1'b0, uf: 1'b0});
    sync = 32'h0;
    for (int i = 0; i < lanes; i++) sync |= 32'hB8 << (8 * i);
    tl.push_back('{lp_p: 4'h0, lp_n: 4'h0, en: 1'b1, data: sync, rdy: 1'b1, uf: 1'b0});
    last = sync;
    for (int w = 0; w < nw; w++) begin
      for (int k = 0; k < beats; k++) begin
        d = (words[w] >> (8 * lanes * k)) & dmask;
        tl.push_back('{lp_p: 4'h0, lp_n: 4'h0, en: 1'b1, data: d,
                       rdy: (k == beats - 1) && !(eop_last && w == nw - 1), uf: 1'b0});
        last = d;
      end
    end
    t = 32'h0;
    for (int i = 0; i < lanes; i++) if (!last[8 * i + 7]) t |= 32'hFF << (8 * i);
    for (int c = 0; c < T_HS_TRAIL; c++)
      tl.push_back('{lp_p: 4'h0, lp_n: 4'h0, en: 1'b1, data: t, rdy: 1'b0, uf: (c == 0) && !eop_last});
    repeat (T_HS_EXIT) tl.push_back(idle_rec(lanes));
    repeat (2)         tl.push_back(idle_rec(lanes));
  endtask

  task automatic drive(input int s, input logic v, input logic [31:0] d, input logic e);
    data_in = d;
    eop_in  = e;
    if (s == 1) valid4 = v;
    else        valid2 = v;
  endtask

  // Sends one packet on instance s (0: 2-lane, 1: 4-lane); rst_cut>0 asserts reset so
  // that the record at that index is the reset state.
  task automatic run_pkt(input int s, input int nw, input logic eop_last, input int rst_cut);
    int   j, ncyc;
    logic acc, v, stopped;
    build_tl(s == 1 ? 4 : 2, nw, eop_last);
    if (rst_cut > 0) begin
      while (tl.size() > rst_cut) void'(tl.pop_back());
      repeat (3) tl.push_back(idle_rec(s == 1 ? 4 : 2));
    end
    ncyc = tl.size();
    @(negedge clk); #1;
    sel     = s;
    pkt_id++;
    rec_idx = 0;
    foreach (tl[i]) exp_q.push_back(tl[i]);
    j = 0; acc = 1'b0; v = 1'b1; stopped = 1'b0;
    drive(s, 1'b1, words[0], eop_last && nw == 1);
    for (int c = 0; c < ncyc; c++) begin
      @(posedge clk); #1;
      if (acc && !stopped) begin
        j++;
        if (j < nw) drive(s, 1'b1, words[j], eop_last && j == nw - 1);
        else begin v = 1'b0; drive(s, 1'b0, 32'h0, 1'b1); end
      end
      acc = v && ((s == 1) ? rdy4 : rdy2);
      if (rst_cut > 0 && c == rst_cut - 1) srst_n = 1'b0;
      if (rst_cut > 0 && c == rst_cut) begin
        srst_n = 1'b1; v = 1'b0; stopped = 1'b1;
        drive(s, 1'b0, 32'h0, 1'b1);
      end
    end
  endtask

  task automatic idle_check(input int n);
    @(negedge clk); #1;
    sel = 0;
    pkt_id++;
    rec_idx = 0;
    repeat (n) exp_q.push_back(idle_rec(2));
    repeat (n) @(posedge clk);
  endtask

  initial begin
    srst_n = 1'b0; valid2 = 1'b0; valid4 = 1'b0; data_in = 32'h0; eop_in = 1'b1;
    @(posedge clk);
    idle_check(3);
    @(negedge clk); #1 srst_n = 1'b1;
    idle_check(6);

    // Two-word packet with hand-computed pins on the model.
    words[0] = 32'h4433_2211; words[1] = 32'h8877_6655;
    build_tl(2, 2, 1'b1);
    pin("len2", 32'(tl.size()), 32'd20);
    pin("sync2", tl[8].data, 32'h0000_B8B8);
    pin("sync_rdy2", 32'(tl[8].rdy), 32'd1);
    pin("beat10", tl[9].data, 32'h0000_2211);
    pin("rdy11", 32'(tl[10].rdy), 32'd1);
    pin("beat13", tl[12].data, 32'h0000_8877);
    pin("trail14", tl[13].data, 32'h0000_00FF);
    pin("lp11_17", 32'(tl[16].lp_p), 32'h3);
    pin("zero5_en", 32'(tl[4].en), 32'd1);
    run_pkt(0, 2, 1'b1, 0);

    // Starved after two non-eop words.
    words[0] = 32'h0102_0304; words[1] = 32'h7FA5_1E0F;
    run_pkt(0, 2, 1'b0, 0);

    // Reset during HS_DATA, then a fresh single-word packet.
    words[0] = 32'hDEAD_BEEF; words[1] = 32'h1234_5678;
    run_pkt(0, 2, 1'b1, 10);
    words[0] = 32'h80FF_0080;
    run_pkt(0, 1, 1'b1, 0);

    // Four lanes: one word per cycle.
    words[0] = 32'h1122_3344; words[1] = 32'h5566_7788; words[2] = 32'h9A2B_3C4D;
    build_tl(4, 3, 1'b1);
    pin("len4", 32'(tl.size()), 32'd19);
    pin("sync4", tl[8].data, 32'hB8B8_B8B8);
    pin("rdy4_w0", 32'(tl[9].rdy), 32'd1);
    pin("rdy4_eop", 32'(tl[11].rdy), 32'd0);
    pin("trail4", tl[12].data, 32'h00FF_FFFF);
    run_pkt(1, 3, 1'b1, 0);

    // Four lanes, single non-eop word then starvation.
    words[0] = 32'h0A0B_0C8D;
    run_pkt(1, 1, 1'b0, 0);

    @(negedge clk); #1;
    n_total++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL drain actual=%0d required=0", exp_q.size());
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
